pst_id_fwd: RTL and testbench

//  Parametrised pipelined decode stage: decode, register-file read, EX/MEM/WB operand forwarding.

---
 rtl/pst_id_fwd.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_pst_id_fwd.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pst_id_fwd.sv
// pst_id_fwd -- instruction decode stage of the scalar pipeline.
//
// Decodes the word held in the IF/ID register, reads the stage-local register
// file, resolves operands by forwarding from EX/MEM/WB, detects load-use
// hazards and latches the result into the ID/EX pipeline register. Bubbles are
// inserted on flush, on a load-use stall and when no valid instruction arrives.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   en                    global pipeline enable; 0 freezes RF, ID/EX and stall_cnt
//   flush                 kill the instruction entering ID/EX
//   in_valid/inst/in_pc   instruction from IF/ID
//   wb_*                  writeback write port, also the lowest-priority forward source
//   mem_*, ex_*           forward sources; ex_is_load marks ex_data as not yet available
//   dbg_rf_req/data       raw combinational register-file read for debug
//   stall                 combinational load-use stall; upstream holds inst/in_pc
//   out_*                 ID/EX pipeline register (operands, fields, controls)
//   stall_cnt             saturating count of stall cycles
module pst_id_fwd #(
  parameter int  XLEN      = 32,
  parameter int  NREG      = 32,
  parameter int  SYS_REG_A = 2,
  parameter int  SYS_REG_B = 4,
  parameter bit  FWD_EN    = 1'b1,
  localparam int RW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_req,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_we,
  input  logic [RW-1:0]   mem_req,
  input  logic [XLEN-1:0] mem_data,
  input  logic            ex_we,
  input  logic [RW-1:0]   ex_req,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic [RW-1:0]   dbg_rf_req,
  output logic [XLEN-1:0] dbg_rf_data,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rf_a,
  output logic [XLEN-1:0] out_rf_b,
  output logic [RW-1:0]   out_req_w,
  output logic [4:0]      out_shamt,
  output logic [15:0]     out_imm16,
  output logic            out_ctl_rf_we,
  output logic [3:0]      out_ctl_alu_op,
  output logic [2:0]      out_ctl_wtg_op,
  output logic [2:0]      out_ctl_dm_op,
  output logic            out_ctl_dm_we,
  output logic            out_ctl_syscall_en,
  output logic            out_ctl_sel_rf_w_pc_4,
  output logic            out_ctl_sel_rf_w_dm,
  output logic            out_ctl_mux_alu_data_y,
  output logic            out_ctl_is_jump,
  output logic            out_ctl_is_branch,
  output logic [31:0]     stall_cnt
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2b;
  // R-type function codes
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;
  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  // Next-pc selection
  localparam logic [2:0] WTG_PC4 = 3'd0, WTG_J = 3'd1, WTG_JR = 3'd2, WTG_BEQ = 3'd3, WTG_BNE = 3'd4;
  // Data-memory access width/sign
  localparam logic [2:0] DM_W = 3'd0, DM_B = 3'd1, DM_BU = 3'd2, DM_H = 3'd3, DM_HU = 3'd4;

  typedef enum logic [1:0] {WSEL_NONE, WSEL_RD, WSEL_RT, WSEL_31} wsel_e;

  typedef struct packed {
    logic       rf_ra;
    logic       rf_rb;
    wsel_e      wsel;
    logic       rf_we;
    logic [3:0] alu_op;
    logic [2:0] wtg_op;
    logic [2:0] dm_op;
    logic       dm_we;
    logic       syscall_en;
    logic       sel_rf_w_pc_4;
    logic       sel_rf_w_dm;
    logic       mux_alu_data_y;
    logic       is_jump;
    logic       is_branch;
  } ctl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [RW-1:0]   req_w;
    logic [4:0]      shamt;
    logic [15:0]     imm16;
    logic            rf_we;
    logic [3:0]      alu_op;
    logic [2:0]      wtg_op;
    logic [2:0]      dm_op;
    logic            dm_we;
    logic            syscall_en;
    logic            sel_rf_w_pc_4;
    logic            sel_rf_w_dm;
    logic            mux_alu_data_y;
    logic            is_jump;
    logic            is_branch;
  } idex_t;

  function automatic logic [3:0] rtype_alu(input logic [5:0] funct);
    logic [3:0] op;
    case (funct)
      F_SUB, F_SUBU: op = ALU_SUB;
      F_AND:         op = ALU_AND;
      F_OR:          op = ALU_OR;
      F_XOR:         op = ALU_XOR;
      F_NOR:         op = ALU_NOR;
      F_SLT:         op = ALU_SLT;
      F_SLTU:        op = ALU_SLTU;
      F_SLL:         op = ALU_SLL;
      F_SRL:         op = ALU_SRL;
      F_SRA:         op = ALU_SRA;
      default:       op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] itype_alu(input logic [5:0] opcode);
    logic [3:0] op;
    case (opcode)
      OP_SLTI:  op = ALU_SLT;
      OP_SLTIU: op = ALU_SLTU;
      OP_ANDI:  op = ALU_AND;
      OP_ORI:   op = ALU_OR;
      OP_XORI:  op = ALU_XOR;
      OP_LUI:   op = ALU_LUI;
      default:  op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Forwarding priority: youngest producer wins. A load in EX has no data yet,
  // so it is skipped here and covered by the stall instead.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [RW-1:0]   req,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_ok,  input logic [RW-1:0] ex_r,  input logic [XLEN-1:0] ex_d,
    input logic            mem_ok, input logic [RW-1:0] mem_r, input logic [XLEN-1:0] mem_d,
    input logic            wb_ok,  input logic [RW-1:0] wb_r,  input logic [XLEN-1:0] wb_d
  );
    logic [XLEN-1:0] val;
    if (req == {RW{1'b0}})                     val = {XLEN{1'b0}};
    else if (FWD_EN && ex_ok && ex_r == req)   val = ex_d;
    else if (FWD_EN && mem_ok && mem_r == req) val = mem_d;
    else if (wb_ok && wb_r == req)             val = wb_d;
    else                                       val = rf_val;
    return val;
  endfunction

  logic [5:0]      opcode_s, funct_s;
  logic [4:0]      rs_s, rt_s, rd_s;
  ctl_t            ctl_s;
  logic [RW-1:0]   req_a_s, req_b_s, req_w_s;
  logic [XLEN-1:0] opd_a_s, opd_b_s;
  logic            stall_s;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  idex_t           idex_q, idex_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  assign opcode_s = inst[31:26];
  assign rs_s     = inst[25:21];
  assign rt_s     = inst[20:16];
  assign rd_s     = inst[15:11];
  assign funct_s  = inst[5:0];

  // Instruction decode into datapath controls
  always_comb begin
    ctl_s      = {$bits(ctl_t){1'b0}};
    ctl_s.wsel = WSEL_NONE;
    case (opcode_s)
      OP_RTYPE: begin
        ctl_s.alu_op = rtype_alu(funct_s);
        case (funct_s)
          F_SLL, F_SRL, F_SRA: begin
            ctl_s.rf_rb = 1'b1;
            ctl_s.rf_we = 1'b1;
            ctl_s.wsel  = WSEL_RD;
          end
          F_JR: begin
            ctl_s.rf_ra   = 1'b1;
            ctl_s.is_jump = 1'b1;
            ctl_s.wtg_op  = WTG_JR;
          end
          F_SYSCALL: begin
            ctl_s.rf_ra      = 1'b1;
            ctl_s.rf_rb      = 1'b1;
            ctl_s.syscall_en = 1'b1;
          end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            ctl_s.rf_ra = 1'b1;
            ctl_s.rf_rb = 1'b1;
            ctl_s.rf_we = 1'b1;
            ctl_s.wsel  = WSEL_RD;
          end
          default: ctl_s.rf_we = 1'b0;
        endcase
      end
      OP_J: begin
        ctl_s.is_jump = 1'b1;
        ctl_s.wtg_op  = WTG_J;
      end
      OP_JAL: begin
        ctl_s.is_jump       = 1'b1;
        ctl_s.wtg_op        = WTG_J;
        ctl_s.rf_we         = 1'b1;
        ctl_s.wsel          = WSEL_31;
        ctl_s.sel_rf_w_pc_4 = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctl_s.rf_ra     = 1'b1;
        ctl_s.rf_rb     = 1'b1;
        ctl_s.is_branch = 1'b1;
        ctl_s.alu_op    = ALU_SUB;
        ctl_s.wtg_op    = (opcode_s == OP_BEQ) ? WTG_BEQ : WTG_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctl_s.rf_ra          = (opcode_s != OP_LUI);
        ctl_s.rf_we          = 1'b1;
        ctl_s.wsel           = WSEL_RT;
        ctl_s.mux_alu_data_y = 1'b1;
        ctl_s.alu_op         = itype_alu(opcode_s);
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctl_s.rf_ra          = 1'b1;
        ctl_s.rf_we          = 1'b1;
        ctl_s.wsel           = WSEL_RT;
        ctl_s.sel_rf_w_dm    = 1'b1;
        ctl_s.mux_alu_data_y = 1'b1;
        case (opcode_s)
          OP_LB:   ctl_s.dm_op = DM_B;
          OP_LBU:  ctl_s.dm_op = DM_BU;
          OP_LH:   ctl_s.dm_op = DM_H;
          OP_LHU:  ctl_s.dm_op = DM_HU;
          default: ctl_s.dm_op = DM_W;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctl_s.rf_ra          = 1'b1;
        ctl_s.rf_rb          = 1'b1;
        ctl_s.dm_we          = 1'b1;
        ctl_s.mux_alu_data_y = 1'b1;
        case (opcode_s)
          OP_SB:   ctl_s.dm_op = DM_B;
          OP_SH:   ctl_s.dm_op = DM_H;
          default: ctl_s.dm_op = DM_W;
        endcase
      end
      default: ctl_s.rf_we = 1'b0;
    endcase
  end

  // Register indices: syscall reads its fixed argument registers
  always_comb begin
    if (ctl_s.syscall_en) begin
      req_a_s = RW'(SYS_REG_A);
      req_b_s = RW'(SYS_REG_B);
    end else begin
      req_a_s = RW'(rs_s);
      req_b_s = RW'(rt_s);
    end
    case (ctl_s.wsel)
      WSEL_RD: req_w_s = RW'(rd_s);
      WSEL_RT: req_w_s = RW'(rt_s);
      WSEL_31: req_w_s = RW'(NREG - 1);
      default: req_w_s = {RW{1'b0}};
    endcase
  end

  // Operand resolution for both read ports
  always_comb begin
    opd_a_s = pick_operand(req_a_s, rf_q[req_a_s],
                           ex_we & ~ex_is_load, ex_req, ex_data,
                           mem_we, mem_req, mem_data, wb_we, wb_req, wb_data);
    opd_b_s = pick_operand(req_b_s, rf_q[req_b_s],
                           ex_we & ~ex_is_load, ex_req, ex_data,
                           mem_we, mem_req, mem_data, wb_we, wb_req, wb_data);
  end

  // Load-use hazard: an operand actually consumed depends on a load still in EX
  always_comb begin
    if (FWD_EN) begin
      stall_s = in_valid & ex_is_load & ex_we & (ex_req != {RW{1'b0}}) &
                ((ctl_s.rf_ra & (ex_req == req_a_s)) | (ctl_s.rf_rb & (ex_req == req_b_s)));
    end else begin
      stall_s = 1'b0;
    end
  end

  // Register-file write port; index 0 stays hard-wired to zero
  always_comb begin
    rf_d = rf_q;
    if (en & wb_we & (wb_req != {RW{1'b0}})) begin
      rf_d[wb_req] = wb_data;
    end else begin
      rf_d = rf_q;
    end
  end

  // Register-file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf_q <= '{default: {XLEN{1'b0}}};
    else        rf_q <= rf_d;
  end

  // ID/EX next state: bubbles clear only the fields that cause side effects
  always_comb begin
    idex_d = idex_q;
    if (!en) begin
      idex_d = idex_q;
    end else if (flush | stall_s | ~in_valid) begin
      idex_d.valid     = 1'b0;
      idex_d.rf_we     = 1'b0;
      idex_d.dm_we     = 1'b0;
      idex_d.is_jump   = 1'b0;
      idex_d.is_branch = 1'b0;
    end else begin
      idex_d.valid          = 1'b1;
      idex_d.pc             = in_pc;
      idex_d.rf_a           = opd_a_s;
      idex_d.rf_b           = opd_b_s;
      idex_d.req_w          = req_w_s;
      idex_d.shamt          = inst[10:6];
      idex_d.imm16          = inst[15:0];
      idex_d.rf_we          = ctl_s.rf_we;
      idex_d.alu_op         = ctl_s.alu_op;
      idex_d.wtg_op         = ctl_s.wtg_op;
      idex_d.dm_op          = ctl_s.dm_op;
      idex_d.dm_we          = ctl_s.dm_we;
      idex_d.syscall_en     = ctl_s.syscall_en;
      idex_d.sel_rf_w_pc_4  = ctl_s.sel_rf_w_pc_4;
      idex_d.sel_rf_w_dm    = ctl_s.sel_rf_w_dm;
      idex_d.mux_alu_data_y = ctl_s.mux_alu_data_y;
      idex_d.is_jump        = ctl_s.is_jump;
      idex_d.is_branch      = ctl_s.is_branch;
    end
  end

  // Saturating stall counter; a flushed stall is not a lost cycle
  always_comb begin
    if (en & stall_s & ~flush & (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    else                                                         stall_cnt_d = stall_cnt_q;
  end

  // ID/EX pipeline register and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= {$bits(idex_t){1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dbg_rf_data            = rf_q[dbg_rf_req];
  assign stall                  = stall_s;
  assign out_valid              = idex_q.valid;
  assign out_pc                 = idex_q.pc;
  assign out_rf_a               = idex_q.rf_a;
  assign out_rf_b               = idex_q.rf_b;
  assign out_req_w              = idex_q.req_w;
  assign out_shamt              = idex_q.shamt;
  assign out_imm16              = idex_q.imm16;
  assign out_ctl_rf_we          = idex_q.rf_we;
  assign out_ctl_alu_op         = idex_q.alu_op;
  assign out_ctl_wtg_op         = idex_q.wtg_op;
  assign out_ctl_dm_op          = idex_q.dm_op;
  assign out_ctl_dm_we          = idex_q.dm_we;
  assign out_ctl_syscall_en     = idex_q.syscall_en;
  assign out_ctl_sel_rf_w_pc_4  = idex_q.sel_rf_w_pc_4;
  assign out_ctl_sel_rf_w_dm    = idex_q.sel_rf_w_dm;
  assign out_ctl_mux_alu_data_y = idex_q.mux_alu_data_y;
  assign out_ctl_is_jump        = idex_q.is_jump;
  assign out_ctl_is_branch      = idex_q.is_branch;
  assign stall_cnt              = stall_cnt_q;

endmodule

// File: tb/tb_pst_id_fwd.sv
module tb_pst_id_fwd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, flush, in_valid;
  logic [31:0] inst, in_pc;
  logic        wb_we, mem_we, ex_we, ex_is_load;
  logic [4:0]  wb_req, mem_req, ex_req, dbg_rf_req;
  logic [31:0] wb_data, mem_data, ex_data;
  logic [31:0] dbg_rf_data;
  logic        stall, out_valid;
  logic [31:0] out_pc, out_rf_a, out_rf_b;
  logic [4:0]  out_req_w, out_shamt;
  logic [15:0] out_imm16;
  logic        out_ctl_rf_we, out_ctl_dm_we, out_ctl_syscall_en;
  logic [3:0]  out_ctl_alu_op;
  logic [2:0]  out_ctl_wtg_op, out_ctl_dm_op;
  logic        out_ctl_sel_rf_w_pc_4, out_ctl_sel_rf_w_dm, out_ctl_mux_alu_data_y;
  logic        out_ctl_is_jump, out_ctl_is_branch;
  logic [31:0] stall_cnt;

  pst_id_fwd dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .inst(inst), .in_pc(in_pc),
    .wb_we(wb_we), .wb_req(wb_req), .wb_data(wb_data),
    .mem_we(mem_we), .mem_req(mem_req), .mem_data(mem_data),
    .ex_we(ex_we), .ex_req(ex_req), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .dbg_rf_req(dbg_rf_req), .dbg_rf_data(dbg_rf_data),
    .stall(stall), .out_valid(out_valid), .out_pc(out_pc),
    .out_rf_a(out_rf_a), .out_rf_b(out_rf_b), .out_req_w(out_req_w),
    .out_shamt(out_shamt), .out_imm16(out_imm16),
    .out_ctl_rf_we(out_ctl_rf_we), .out_ctl_alu_op(out_ctl_alu_op),
    .out_ctl_wtg_op(out_ctl_wtg_op), .out_ctl_dm_op(out_ctl_dm_op),
    .out_ctl_dm_we(out_ctl_dm_we), .out_ctl_syscall_en(out_ctl_syscall_en),
    .out_ctl_sel_rf_w_pc_4(out_ctl_sel_rf_w_pc_4), .out_ctl_sel_rf_w_dm(out_ctl_sel_rf_w_dm),
    .out_ctl_mux_alu_data_y(out_ctl_mux_alu_data_y),
    .out_ctl_is_jump(out_ctl_is_jump), .out_ctl_is_branch(out_ctl_is_branch),
    .stall_cnt(stall_cnt)
  );

  always #50 clk = ~clk;

  // Expected ID/EX contents after one clock edge
  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b;
    logic [4:0]  rw, sh;
    logic        we, dmwe, sys, jmp, br;
    logic [15:0] imm;
    logic [31:0] cnt;
  } exp_t;

  // What an instruction reads/writes, from the ISA description
  typedef struct packed {
    logic       ra, rb, we, dmwe, sys, jmp, br;
    logic [4:0] dst;
  } info_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] rf_m [32];
  logic        last_stall;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic info_t classify(input logic [31:0] w);
    info_t d = '0;
    case (w[31:26])
      6'h00: begin
        d.ra = 1'b1; d.rb = 1'b1;
        if (w[5:0] == 6'h0c) d.sys = 1'b1;
        else begin d.we = 1'b1; d.dst = w[15:11]; end
      end
      6'h08, 6'h23: begin d.ra = 1'b1; d.we = 1'b1; d.dst = w[20:16]; end
      6'h2b:        begin d.ra = 1'b1; d.rb = 1'b1; d.dmwe = 1'b1; end
      6'h04:        begin d.ra = 1'b1; d.rb = 1'b1; d.br = 1'b1; end
      6'h03:        begin d.we = 1'b1; d.jmp = 1'b1; d.dst = 5'd31; end
      default:      d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (ex_we && !ex_is_load && ex_req == r) return ex_data;
    if (mem_we && mem_req == r) return mem_data;
    if (wb_we && wb_req == r) return wb_data;
    return rf_m[r];
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rs = 5'($urandom % 8);
    logic [4:0]  rt = 5'($urandom % 8);
    logic [4:0]  rd = 5'($urandom % 8);
    logic [15:0] imm = 16'($urandom);
    case ($urandom % 7)
      0:       return enc_r(rs, rt, rd, 6'h20);
      1:       return {6'h08, rs, rt, imm};
      2:       return {6'h23, rs, rt, imm};
      3:       return {6'h2b, rs, rt, imm};
      4:       return {6'h04, rs, rt, imm};
      5:       return {6'h03, 26'($urandom)};
      default: return enc_r(rs, rt, rd, 6'h0c);
    endcase
  endfunction

  task automatic set_idle();
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = 32'd0; in_pc = 32'd0;
    wb_we = 1'b0; wb_req = 5'd0; wb_data = 32'd0;
    mem_we = 1'b0; mem_req = 5'd0; mem_data = 32'd0;
    ex_we = 1'b0; ex_req = 5'd0; ex_data = 32'd0; ex_is_load = 1'b0;
    dbg_rf_req = 5'd0;
  endtask

  task automatic model_reset();
    cur = '0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    last_stall = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied; predicts the next
  // rising edge, queues the expectation and returns at the following falling edge.
  task automatic step();
    info_t      d;
    logic [4:0] ra, rb;
    logic       st;
    #1;
    d  = classify(inst);
    ra = d.sys ? 5'd2 : inst[25:21];
    rb = d.sys ? 5'd4 : inst[20:16];
    st = in_valid && ex_is_load && ex_we && ex_req != 5'd0 &&
         ((d.ra && ex_req == ra) || (d.rb && ex_req == rb));
    last_stall = st;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("dbg_rf_data", dbg_rf_data, rf_m[dbg_rf_req]);
    if (en) begin
      if (flush || st || !in_valid) begin
        cur.v = 1'b0; cur.we = 1'b0; cur.dmwe = 1'b0; cur.jmp = 1'b0; cur.br = 1'b0;
      end else begin
        cur.v = 1'b1; cur.pc = in_pc; cur.a = operand(ra); cur.b = operand(rb);
        cur.rw = d.dst; cur.sh = inst[10:6]; cur.imm = inst[15:0];
        cur.we = d.we; cur.dmwe = d.dmwe; cur.sys = d.sys; cur.jmp = d.jmp; cur.br = d.br;
      end
      if (st && !flush && cur.cnt != 32'hFFFF_FFFF) cur.cnt = cur.cnt + 32'd1;
      if (wb_we && wb_req != 5'd0) rf_m[wb_req] = wb_data;
    end
    sb.push_back(cur);
    @(negedge clk);
  endtask

  // Monitor: compares the registered outputs after every rising edge that has a prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
        chk("out_pc", out_pc, e.pc);
        chk("out_rf_a", out_rf_a, e.a);
        chk("out_rf_b", out_rf_b, e.b);
        chk("out_req_w", {27'd0, out_req_w}, {27'd0, e.rw});
        chk("out_shamt", {27'd0, out_shamt}, {27'd0, e.sh});
        chk("out_imm16", {16'd0, out_imm16}, {16'd0, e.imm});
        chk("ctl_flags", {27'd0, out_ctl_rf_we, out_ctl_dm_we, out_ctl_syscall_en,
                          out_ctl_is_jump, out_ctl_is_branch},
                         {27'd0, e.we, e.dmwe, e.sys, e.jmp, e.br});
        chk("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    chk("reset_rf_a", out_rf_a, 32'd0);
    rst_n = 1'b1;

    // WB write-through into the decoding instruction
    set_idle(); in_valid = 1'b1; in_pc = 32'h100;
    inst = enc_r(5'd5, 5'd0, 5'd3, 6'h20);
    wb_we = 1'b1; wb_req = 5'd5; wb_data = 32'h1234;
    step();
    chk("wt_rf_a", out_rf_a, 32'h1234);
    chk("wt_rf_b", out_rf_b, 32'd0);

    // Forward priority ex > mem > wb
    set_idle(); in_valid = 1'b1; in_pc = 32'h104;
    inst = enc_r(5'd7, 5'd0, 5'd1, 6'h20);
    ex_we = 1'b1;  ex_req = 5'd7;  ex_data = 32'hA;
    mem_we = 1'b1; mem_req = 5'd7; mem_data = 32'hB;
    wb_we = 1'b1;  wb_req = 5'd7;  wb_data = 32'hC;
    step();
    chk("prio_ex", out_rf_a, 32'hA);
    ex_we = 1'b0;
    step();
    chk("prio_mem", out_rf_a, 32'hB);
    mem_we = 1'b0;
    step();
    chk("prio_wb", out_rf_a, 32'hC);

    // Load-use: one bubble, then the load's data arrives from MEM
    set_idle(); in_valid = 1'b1; in_pc = 32'h108;
    inst = enc_r(5'd8, 5'd2, 5'd1, 6'h20);
    ex_we = 1'b1; ex_is_load = 1'b1; ex_req = 5'd8; ex_data = 32'hDEAD;
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_cnt", stall_cnt, 32'd1);
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b1; mem_req = 5'd8; mem_data = 32'h55;
    step();
    chk("lu_fwd", out_rf_a, 32'h55);
    chk("lu_valid", {31'd0, out_valid}, 32'd1);

    // Flush together with a stall: bubble, counter untouched
    mem_we = 1'b0; ex_we = 1'b1; ex_is_load = 1'b1; ex_req = 5'd8; flush = 1'b1;
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_rf_we", {31'd0, out_ctl_rf_we}, 32'd0);
    chk("fl_cnt", stall_cnt, 32'd1);

    // Randomized traffic; a stalled instruction is held upstream
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom % 8) != 0;
      flush    = ($urandom % 10) == 0;
      in_valid = ($urandom % 8) != 0;
      if (!last_stall) begin
        inst  = gen_inst();
        in_pc = $urandom & 32'hFFFF_FFFC;
      end
      wb_we  = 1'($urandom); wb_req  = 5'($urandom % 8); wb_data  = $urandom;
      mem_we = 1'($urandom); mem_req = 5'($urandom % 8); mem_data = $urandom;
      ex_we  = 1'($urandom); ex_req  = 5'($urandom % 8); ex_data  = $urandom;
      ex_is_load = ($urandom % 3) == 0;
      dbg_rf_req = 5'($urandom % 8);
      step();
    end

    // One more valid instruction, then freeze and let the monitor drain
    set_idle(); in_valid = 1'b1; in_pc = 32'h200; inst = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    step();
    en = 1'b0; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    chk("drain", sb.size(), 32'd0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_cnt", stall_cnt, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_rf_req = 5'(i);
      #1 chk("async_rf", dbg_rf_data, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();

    // Syscall reads its fixed argument registers
    wb_we = 1'b1; wb_req = 5'd2; wb_data = 32'd10;
    step();
    wb_req = 5'd4; wb_data = 32'h100;
    step();
    wb_we = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
    inst = enc_r(5'd9, 5'd9, 5'd0, 6'h0c);
    step();
    chk("sys_a", out_rf_a, 32'd10);
    chk("sys_b", out_rf_b, 32'h100);
    chk("sys_en", {31'd0, out_ctl_syscall_en}, 32'd1);

    // Enable low: everything holds regardless of inputs
    for (int n = 0; n < 3; n++) begin
      en = 1'b0; flush = 1'($urandom); in_valid = 1'($urandom); inst = gen_inst();
      in_pc = $urandom; wb_we = 1'b1; wb_req = 5'd2; wb_data = $urandom;
      step();
    end
    chk("hold_a", out_rf_a, 32'd10);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_pc", out_pc, 32'h300);

    repeat (2) begin @(posedge clk); #2; end
    chk("final_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
